branch_flag_unit: RTL

BRANCH_FLAG_UNIT -- requirements
Module: branch_flag_unit

---
 rtl/branch_flag_unit_pkg.sv | 16 +
 rtl/branch_flag_unit_flag_reg.sv | 38 +++
 rtl/branch_flag_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/branch_flag_unit_pkg.sv
// Shared types and constants for the branch flag unit.
package branch_flag_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_OR    = 0;
  localparam int FLAG_GT    = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NZERO = 3;
  localparam int FLAG_OVF   = 4;

endpackage

// File: rtl/branch_flag_unit_flag_reg.sv
// ALU flag register with one sticky bit.
// Also exposes the forwarded view used by same-cycle evaluation.
module flag_reg
  import branch_flag_unit_pkg::*;
#(
  parameter int FLAG_W     = 5,
  parameter int STICKY_BIT = FLAG_OVF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              flag_we,
  input  logic              sticky_clr,
  output logic [FLAG_W-1:0] flags_q,
  output logic [FLAG_W-1:0] flags_fwd
);

  logic [FLAG_W-1:0] flags_nxt;

  always_comb begin
    flags_nxt = flags_q;
    if (flag_we) flags_nxt = flags_in;
    // a clear wins over the old sticky value, never over new data
    if (sticky_clr)
      flags_nxt[STICKY_BIT] = flag_we & flags_in[STICKY_BIT];
    else
      flags_nxt[STICKY_BIT] = flags_q[STICKY_BIT]
                            | (flag_we & flags_in[STICKY_BIT]);
  end

  assign flags_fwd = flag_we ? flags_nxt : flags_q;

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_nxt;
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Branch condition evaluator: flag register plus
// a three-state select/evaluate/hold FSM.
module branch_flag_unit
  import branch_flag_unit_pkg::*;
#(
  parameter int FLAG_W     = 5,
  parameter int NUM_COND   = 8,
  parameter int STICKY_BIT = FLAG_OVF,
  localparam int SEL_W     = $clog2(NUM_COND)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              flag_we,
  input  logic              sticky_clr,
  input  logic              eval_req,
  input  logic [SEL_W-1:0]  cond_sel,
  input  logic              cond_inv,
  output logic              eval_busy,
  output logic              taken_valid,
  output logic              taken,
  input  logic              taken_ack,
  output logic [FLAG_W-1:0] flags_q
);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_q;
  logic              inv_q;
  logic              raw;
  logic [FLAG_W-1:0] flags_fwd;

  flag_reg #(
    .FLAG_W     (FLAG_W),
    .STICKY_BIT (STICKY_BIT)
  ) u_flag_reg (
    .clk        (clk),
    .reset      (reset),
    .flags_in   (flags_in),
    .flag_we    (flag_we),
    .sticky_clr (sticky_clr),
    .flags_q    (flags_q),
    .flags_fwd  (flags_fwd)
  );

  // codes past the flags: FLAG_W is "always", above is "never"
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < FLAG_W; i++)
      if (int'(sel_q) == i) raw = flags_fwd[i];
    if (int'(sel_q) == FLAG_W) raw = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (eval_req) state_nxt = EVAL;
      EVAL:    state_nxt = DONE;
      DONE:    if (taken_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
      inv_q <= 1'b0;
      taken <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && eval_req) begin
        sel_q <= cond_sel;
        inv_q <= cond_inv;
      end
      if (state == EVAL) taken <= raw ^ inv_q;
    end
  end

  assign eval_busy   = (state != IDLE);
  assign taken_valid = (state == DONE);

endmodule
